// File: rtl/mult_div_unit_if.sv
// Bus between the pipeline control and mult_div_unit.
//   start/op       : launch a MULT/MULTU/DIV/DIVU (op 00/01/10/11)
//   Rs_data/Rt_data: operands; Rs_data is also the MTHI/MTLO source
//   mthi/mtlo      : move Rs_data into HI/LO
//   busy/done      : operation in progress / one-cycle result-ready pulse
//   HI/LO          : architectural result registers
interface mult_div_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] Rs_data;
    logic [DATA_W-1:0] Rt_data;
    logic              mthi;
    logic              mtlo;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] HI;
    logic [DATA_W-1:0] LO;

    modport master (
        output start, op, Rs_data, Rt_data, mthi, mtlo,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, op, Rs_data, Rt_data, mthi, mtlo,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : mult_div_unit_if slave (start/op/operands/moves in, busy/done/HI/LO out)
// Fixed latency: 32 CALC cycles + 1 FIX cycle, then a one-cycle DONE state.
// Multiply is radix-2 shift-add, divide is restoring shift-subtract; both work
// on operand magnitudes with signs applied in FIX.
module mult_div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input logic            clk,
    input logic            rst,
    mult_div_unit_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

    logic [1:0]          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;       // multiplicand / dividend magnitude
    logic [DATA_W-1:0]   b_q, b_d;       // multiplier / divisor magnitude
    logic [2*DATA_W-1:0] acc_q, acc_d;   // mul: {hi, lo}; div: {rem, quot}
    logic                neg_res_q, neg_res_d;  // negate product / quotient
    logic                neg_rem_q, neg_rem_d;  // negate remainder
    logic                dz_q, dz_d;            // divide by zero
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                is_signed;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift, div_diff;
    logic                div_ge;
    logic [2*DATA_W-1:0] mul_step, div_step, prod_neg;

    assign is_signed = ~bus.op[0];
    assign a_mag = (is_signed && bus.Rs_data[DATA_W-1]) ? -bus.Rs_data : bus.Rs_data;
    assign b_mag = (is_signed && bus.Rt_data[DATA_W-1]) ? -bus.Rt_data : bus.Rt_data;

    // Shift-add: add multiplicand to the high half when the current multiplier
    // bit (acc LSB) is set, then shift the whole accumulator right by one.
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_step = {mul_sum, acc_q[DATA_W-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract the divisor only if it does not go negative.
    assign div_shift = acc_q[2*DATA_W-1:DATA_W-1];
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = ~div_diff[DATA_W];
    assign div_step  = {(div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                        acc_q[DATA_W-2:0], div_ge};

    assign prod_neg = -acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    // start wins over a simultaneous move
                    op_d      = bus.op;
                    a_d       = a_mag;
                    b_d       = b_mag;
                    neg_res_d = is_signed && (bus.Rs_data[DATA_W-1] ^ bus.Rt_data[DATA_W-1]);
                    neg_rem_d = is_signed && bus.op[1] && bus.Rs_data[DATA_W-1];
                    dz_d      = bus.op[1] && (bus.Rt_data == '0);
                    acc_d     = bus.op[1] ? {{DATA_W{1'b0}}, a_mag} : {{DATA_W{1'b0}}, b_mag};
                    cnt_d     = '0;
                    state_d   = CALC;
                end else begin
                    if (bus.mthi) hi_d = bus.Rs_data;
                    if (bus.mtlo) lo_d = bus.Rs_data;
                end
            end
            CALC: begin
                acc_d = op_q[1] ? div_step : mul_step;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) state_d = FIX;
            end
            FIX: begin
                if (op_q[1]) begin
                    // Zero divisor leaves the remainder equal to |Rs|; restoring
                    // the dividend sign yields the original Rs_data.
                    lo_d = dz_q      ? '1 :
                           neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy = (state_q == CALC) || (state_q == FIX);
    assign bus.done = (state_q == DONE);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit.
module tb_mult_div_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   bsy;
    int   done_cnt;

    mult_div_unit_if #(.DATA_W(32)) bus ();

    mult_div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation cycle: accumulate busy for the current cycle, then advance.
    task automatic tick_op();
        if (bus.busy) bsy++;
        tick();
        cyc++;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.op      = o;
        bus.Rs_data = a;
        bus.Rt_data = b;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        cyc = 1;
        bsy = 0;
    endtask

    task automatic wait_done();
        while (!bus.done && cyc < 100) tick_op();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.Rs_data = '0;
        bus.Rt_data = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", bus.HI, 32'h0);
        check("rst_lo", bus.LO, 32'h0);
        rst = 1'b1;
        tick();

        // MULT -3 * 5
        launch(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done();
        check("mult_lat", 32'(cyc), 32'd34);
        check("mult_busy_cycles", 32'(bsy), 32'd33);
        check("mult_done_busy", 32'(bus.busy), 32'd0);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFF1);
        tick();
        check("mult_done_pulse", 32'(bus.done), 32'd0);

        // MULTU max*max, then DIV -7/2 launched in the DONE cycle
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done();
        check("multu_hi", bus.HI, 32'hFFFF_FFFE);
        check("multu_lo", bus.LO, 32'h0000_0001);
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        check("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done();
        check("div_lat", 32'(cyc), 32'd34);
        check("div_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_hi", bus.HI, 32'hFFFF_FFFF);

        // Divide by zero and overflow corner
        launch(2'b11, 32'd100, 32'd0);
        wait_done();
        check("divu0_lat", 32'(cyc), 32'd34);
        check("divu0_lo", bus.LO, 32'hFFFF_FFFF);
        check("divu0_hi", bus.HI, 32'd100);
        launch(2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_done();
        check("div0_lo", bus.LO, 32'hFFFF_FFFF);
        check("div0_hi", bus.HI, 32'hFFFF_FFFB);
        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        check("divovf_lo", bus.LO, 32'h8000_0000);
        check("divovf_hi", bus.HI, 32'h0);
        tick();

        // Moves in IDLE
        bus.Rs_data = 32'h1234_5678;
        bus.mthi    = 1'b1;
        tick();
        bus.mthi = 1'b0;
        check("mthi_hi", bus.HI, 32'h1234_5678);
        check("mthi_lo_kept", bus.LO, 32'h8000_0000);
        bus.Rs_data = 32'hA5A5_0F0F;
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        tick();
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthilo_hi", bus.HI, 32'hA5A5_0F0F);
        check("mthilo_lo", bus.LO, 32'hA5A5_0F0F);

        // start + mthi together: start wins; then MTLO while busy is ignored
        bus.mthi = 1'b1;
        launch(2'b01, 32'd3, 32'd4);
        bus.mthi = 1'b0;
        check("startmthi_hi", bus.HI, 32'hA5A5_0F0F);
        for (int i = 0; i < 5; i++) tick_op();
        bus.Rs_data = 32'hDEAD_BEEF;
        bus.mtlo    = 1'b1;
        tick_op();
        bus.mtlo = 1'b0;
        check("mtlo_busy_lo", bus.LO, 32'hA5A5_0F0F);
        check("startmthi_hi_hold", bus.HI, 32'hA5A5_0F0F);
        wait_done();
        check("multu34_lat", 32'(cyc), 32'd34);
        check("multu34_hi", bus.HI, 32'h0);
        check("multu34_lo", bus.LO, 32'd12);

        // start pulsed while busy is ignored
        launch(2'b00, 32'd7, 32'd6);
        for (int i = 0; i < 9; i++) tick_op();
        bus.op      = 2'b11;
        bus.Rs_data = 32'd100;
        bus.Rt_data = 32'd3;
        bus.start   = 1'b1;
        tick_op();
        bus.start = 1'b0;
        wait_done();
        check("ign_lat", 32'(cyc), 32'd34);
        check("ign_lo", bus.LO, 32'd42);
        check("ign_hi", bus.HI, 32'h0);

        // Reset in the middle of a DIVU
        launch(2'b11, 32'd1000, 32'd7);
        for (int i = 0; i < 14; i++) tick_op();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_hi", bus.HI, 32'h0);
        check("midrst_lo", bus.LO, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) done_cnt++;
            tick();
        end
        check("midrst_no_done", 32'(done_cnt), 32'd0);
        check("midrst_lo_after", bus.LO, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It consumes the two register-file read ports (Rs_data, Rt_data) as operands for MULT/MULTU/DIV/DIVU. It holds the 64-bit result in HI/LO for later MFHI/MFLO writeback through the register file's Rd_data path. Control stalls the pipeline while `busy` is high.

## Interface
- `DATA_W`, 32, operand and HI/LO width; only 32 is supported.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `start`  input  1  launch an operation; accepted only when `busy`=0.
- `op`  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `Rs_data`  input  32  operand A (multiplicand / dividend); also the MTHI/MTLO source.
- `Rt_data`  input  32  operand B (multiplier / divisor).
- `mthi`  input  1  write Rs_data into HI.
- `mtlo`  input  1  write Rs_data into LO.
- `busy`  output  1  operation in progress (CALC or FIX).
- `done`  output  1  one-cycle pulse: HI/LO now hold the new result.
- `HI`  output  32  HI register (product high word / remainder).
- `LO`  output  32  LO register (product low word / quotient).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with `start`=1:
  - capture `op`.
  - capture the magnitudes of Rs_data and Rt_data; magnitudes apply to signed ops only, unsigned ops pass the raw values.
  - record the result signs.
  - clear the 6-bit iteration counter and go to CALC.
- CALC: one iteration per cycle, 32 cycles (counter 0..31); go to FIX after iteration 31.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing a 32-bit quotient and a 32-bit remainder.
- FIX:
  - Apply sign correction. Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: the quotient is negated if the signs differ. The remainder takes the dividend's sign.
  - Write HI/LO, then go to DONE.
- DONE: `done`=1 for exactly this cycle. Next state is IDLE, or CALC if `start`=1.
- Divide by zero (Rt_data=0, DIV or DIVU): full latency is kept. Result is LO=32'hFFFF_FFFF, HI=original Rs_data (not sign-corrected).
- DIV 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0 (wraps, no trap).
- MTHI/MTLO:
  - Honoured only in IDLE or DONE. HI and/or LO are written from Rs_data at the clock edge.
  - Both may be asserted together; both registers are then written.
  - Ignored while `busy`=1.
- Simultaneous events:
  - `start` together with `mthi`/`mtlo` in IDLE/DONE: `start` wins and the move is dropped.
  - `start` while `busy`=1: ignored, with no effect on the running operation.
- HI/LO change only on an MTHI/MTLO write, on the FIX→DONE edge, or on reset. They hold their previous values throughout CALC/FIX.

## Timing
- Reset (rst=0 at a rising edge): state=IDLE, counter=0, HI=0, LO=0, busy=0, done=0. Reset mid-operation aborts immediately and clears HI/LO.
- `start` sampled at edge E0.
  - CALC occupies cycles E0+1..E0+32.
  - FIX is cycle E0+33. HI/LO update at the end of it (edge E0+34).
  - `done`=1 during cycle E0+34.
  - Fixed latency: 34 cycles from the start edge to the `done` cycle, independent of operands and op.
- `busy`=1 from E0+1 through E0+33 inclusive; 0 in IDLE and DONE.
- Back-to-back: a `start` in the DONE cycle launches the next operation with no idle bubble.
- `busy` and `done` are registered outputs (decoded directly from the state register), with no combinational path from inputs.

## Test plan
- MULT Rs=0xFFFF_FFFD (-3), Rt=5 -> after 34 cycles done=1, HI=0xFFFF_FFFF, LO=0xFFFF_FFF1; busy high for exactly 33 cycles.
- MULTU Rs=Rt=0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001; then DIV Rs=0xFFFF_FFF9 (-7), Rt=2 started in the DONE cycle -> LO=0xFFFF_FFFD, HI=0xFFFF_FFFF, done 34 cycles later.
- DIVU Rs=100, Rt=0 -> LO=0xFFFF_FFFF, HI=100; DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- Check move handling:
  - MTHI Rs=0x1234_5678 in IDLE -> HI=0x1234_5678 next cycle.
  - MTLO asserted while busy -> LO unchanged.
  - start+mthi together in IDLE -> operation runs, and HI stays unchanged until FIX writes it.
- MULT 7*6 running; `start` with new operands pulsed at cycle 10 -> ignored, LO=42, HI=0.
- rst=0 at cycle 15 of a DIVU -> next cycle busy=0, done=0, HI=LO=0; no done pulse follows.
